// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: word and register-address widths and types,
// used by the register file, decoder and datapath.
package mips_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file: selects a register by
// address and forces the result to zero when register 0 is addressed.
module regfile_read_port
  import mips_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0]                  i_addr,
  input  logic [2**ADDR_W-1:0][WIDTH-1:0]    i_regs,
  output logic [WIDTH-1:0]                   o_data
);

  // Register 0 has no storage behind it, so the zero is produced here
  // rather than trusting whatever sits in slot 0 of the input bundle.
  always_comb begin
    o_data = '0;
    if (i_addr != ADDR_W'(REG_ZERO)) begin
      o_data = i_regs[i_addr];
    end
  end

endmodule

// File: rtl/register_file.sv
// MIPS general-purpose register file: 31 stored registers plus hardwired zero,
// two combinational read ports, one write port updated on the falling clock edge.
module register_file
  import mips_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RW,
  input  logic [WIDTH-1:0]  BusW,
  input  logic              RegWr,
  output logic [WIDTH-1:0]  BusA,
  output logic [WIDTH-1:0]  BusB
);

  localparam int DEPTH = 2**ADDR_W;

  logic [WIDTH-1:0]              r_regs [1:DEPTH-1];
  logic [DEPTH-1:1]              w_wr_sel;
  logic [DEPTH-1:0][WIDTH-1:0]   w_regs;

  // One-hot write decode; address 0 has no select line so its writes vanish.
  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_decode
      assign w_wr_sel[gi] = RegWr && (RW == ADDR_W'(gi));
    end
  endgenerate

  // Storage updates on the falling edge so a value written mid-cycle is
  // readable before the next rising edge; reset wins over any write.
  always_ff @(negedge Clk) begin
    for (int i = 1; i < DEPTH; i++) begin
      if (Rst) begin
        r_regs[i] <= '0;
      end else if (w_wr_sel[i]) begin
        r_regs[i] <= BusW;
      end
    end
  end

  assign w_regs[0] = '0;
  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_bundle
      assign w_regs[gi] = r_regs[gi];
    end
  endgenerate

  regfile_read_port #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_port_a (
    .i_addr (RA),
    .i_regs (w_regs),
    .o_data (BusA)
  );

  regfile_read_port #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_port_b (
    .i_addr (RB),
    .i_regs (w_regs),
    .o_data (BusB)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vectors with literal
// expectations plus a per-edge comparison against an array model.
module tb_register_file;

  logic        clk;
  logic        Rst;
  logic [4:0]  RA;
  logic [4:0]  RB;
  logic [4:0]  RW;
  logic [31:0] BusW;
  logic        RegWr;
  logic [31:0] BusA;
  logic [31:0] BusB;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [0:31];
  bit          model_valid = 0;

  register_file dut (
    .Clk   (clk),
    .Rst   (Rst),
    .RA    (RA),
    .RB    (RB),
    .RW    (RW),
    .BusW  (BusW),
    .RegWr (RegWr),
    .BusA  (BusA),
    .BusB  (BusB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: storage changes only at falling edges, reset clears, r0 never stored.
  always @(negedge clk) begin
    if (Rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      model_valid = 1;
    end else if (RegWr && RW != 5'd0) begin
      model[RW] = BusW;
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : model[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic compare_ports(input string where);
    if (model_valid) begin
      check({"model_busA_", where}, BusA, model_read(RA));
      check({"model_busB_", where}, BusB, model_read(RB));
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      compare_ports("pos");
      @(negedge clk); #2;
      compare_ports("neg");
    end
  end

  // Advance past the next falling edge (the write/reset edge).
  task automatic fall();
    @(negedge clk); #1;
  endtask

  initial begin
    Rst = 1'b1; RA = '0; RB = '0; RW = '0; BusW = '0; RegWr = 1'b0;
    fall(); fall();
    Rst = 1'b0;
    #1;
    check("reset_busA_r0", BusA, 32'd0);
    check("reset_busB_r0", BusB, 32'd0);
    RA = 5'd5; RB = 5'd31; #1;
    check("reset_busA_r5", BusA, 32'd0);
    check("reset_busB_r31", BusB, 32'd0);
    $display("reset: BusA=0x%08h BusB=0x%08h", BusA, BusB);

    // Write to register 0 is discarded.
    RA = 5'd0; RB = 5'd0; RW = 5'd0; BusW = 32'h12345678; RegWr = 1'b1;
    fall();
    RegWr = 1'b0; #1;
    check("r0_write_busA", BusA, 32'd0);
    check("r0_write_busB", BusB, 32'd0);
    $display("write r0: BusA=0x%08h BusB=0x%08h", BusA, BusB);

    // Load register i with value i.
    for (int i = 1; i < 32; i++) begin
      RW = 5'(i); BusW = 32'(i); RegWr = 1'b1;
      fall();
      $display("write r%0d <= 0x%08h", i, 32'(i));
    end
    RegWr = 1'b0;

    // Read back in pairs; the final pair pairs 31 with register 0.
    for (int k = 0; k < 16; k++) begin
      RA = 5'(2*k + 1);
      RB = (k == 15) ? 5'd0 : 5'(2*k + 2);
      #1;
      check("pair_busA", BusA, 32'(2*k + 1));
      check("pair_busB", BusB, (k == 15) ? 32'd0 : 32'(2*k + 2));
      $display("read RA=%0d RB=%0d: BusA=0x%08h BusB=0x%08h", RA, RB, BusA, BusB);
    end

    // Same-cycle read of the register being written: old value before the edge.
    RA = 5'd1; RB = 5'd2; RW = 5'd1; BusW = 32'h12345678; RegWr = 1'b1;
    #1;
    check("pre_edge_busA", BusA, 32'd1);
    check("pre_edge_busB", BusB, 32'd2);
    fall();
    check("post_edge_busA", BusA, 32'h12345678);
    check("post_edge_busB", BusB, 32'd2);
    RegWr = 1'b0;
    $display("write-through r1: BusA=0x%08h BusB=0x%08h", BusA, BusB);

    // Disabled write leaves everything alone.
    RA = 5'd3; RW = 5'd3; BusW = 32'h12345678; RegWr = 1'b0;
    fall();
    check("nowrite_busA_r3", BusA, 32'd3);
    for (int r = 0; r < 32; r++) begin
      RB = 5'(r); #1;
      check("nowrite_sweep", BusB, (r == 1) ? 32'h12345678 : 32'(r));
    end
    $display("no-write r3: BusA=0x%08h", BusA);

    // Reset beats a simultaneous write.
    Rst = 1'b1; RegWr = 1'b1; RW = 5'd5; BusW = 32'hFFFFFFFF;
    fall();
    Rst = 1'b0; RegWr = 1'b0;
    for (int r = 0; r < 32; r++) begin
      RA = 5'(r); RB = 5'(31 - r); #1;
      check("rst_prio_busA", BusA, 32'd0);
      check("rst_prio_busB", BusB, 32'd0);
    end
    $display("reset+write r5: all registers cleared, RA=5 -> checked");

    // Both ports on the same register.
    RW = 5'd7; BusW = 32'hA5A5A5A5; RegWr = 1'b1;
    fall();
    RegWr = 1'b0; RA = 5'd7; RB = 5'd7; #1;
    check("dual_busA_r7", BusA, 32'hA5A5A5A5);
    check("dual_busB_r7", BusB, 32'hA5A5A5A5);
    $display("dual read r7: BusA=0x%08h BusB=0x%08h", BusA, BusB);

    fall(); fall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
